// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the RV32I execute stage and a single-outstanding
// req/gnt/rvld data bus; faults (misaligned, illegal, timeout) never reach the bus.
module lsu_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ld,
    input  logic        i_st,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdata_vld,
    output logic        o_fault,
    output logic [1:0]  o_fault_cause,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvld,
    input  logic [31:0] i_bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_f3;
    logic [1:0]    r_off;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic          r_req;
    logic [31:0]   r_rdata;
    logic          r_rdata_vld;
    logic          r_fault;
    logic [1:0]    r_cause;

    logic          w_illegal;
    logic          w_misal;
    logic          w_tmo;
    logic          w_issue;
    logic          w_cap;
    logic          w_flt;
    logic [1:0]    w_cause;

    function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] wd;
        case (f3[1:0])
            2'b00:   wd = {4{d[7:0]}};
            2'b01:   wd = {2{d[15:0]}};
            default: wd = d;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] sh_b;
        logic [31:0] sh_h;
        logic [31:0] res;
        sh_b = word >> {off, 3'b000};
        sh_h = word >> {off[1], 4'b0000};
        case (f3)
            3'b000:  res = {{24{sh_b[7]}}, sh_b[7:0]};
            3'b001:  res = {{16{sh_h[15]}}, sh_h[15:0]};
            3'b100:  res = {24'h000000, sh_b[7:0]};
            3'b101:  res = {16'h0000, sh_h[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // lhu (101) shares the halfword size code; 011 is never a legal size.
    assign w_illegal = (i_ld & i_st)
                     | (i_ld & ((i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11)))
                     | (i_st & (i_funct3 >= 3'b011));
    assign w_misal   = ((i_funct3[1:0] == 2'b01) & i_addr[0])
                     | ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
    assign w_tmo     = (r_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a grant or data beat in the last counted cycle beats the timeout.
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_cap   = 1'b0;
        w_flt   = 1'b0;
        w_cause = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (i_ld | i_st) begin
                    if (w_illegal) begin
                        w_next  = S_DONE;
                        w_flt   = 1'b1;
                        w_cause = 2'b10;
                    end else if (w_misal) begin
                        w_next  = S_DONE;
                        w_flt   = 1'b1;
                        w_cause = 2'b01;
                    end else begin
                        w_next  = S_REQ;
                        w_issue = 1'b1;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (i_bus_gnt) begin
                    if (r_we) begin
                        w_next = S_DONE;
                    end else if (i_bus_rvld) begin
                        w_next = S_DONE;
                        w_cap  = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end else if (w_tmo) begin
                    w_next  = S_DONE;
                    w_flt   = 1'b1;
                    w_cause = 2'b11;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_WAIT: begin
                if (i_bus_rvld) begin
                    w_next = S_DONE;
                    w_cap  = 1'b1;
                end else if (w_tmo) begin
                    w_next  = S_DONE;
                    w_flt   = 1'b1;
                    w_cause = 2'b11;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Stall output: combinational in IDLE so the request is held on its first cycle.
    always_comb begin
        o_stall = 1'b0;
        case (r_state)
            S_IDLE:  o_stall = i_ld | i_st;
            S_REQ:   o_stall = 1'b1;
            S_WAIT:  o_stall = 1'b1;
            S_DONE:  o_stall = 1'b0;
            default: o_stall = 1'b0;
        endcase
    end

    // Registered bus fields, timeout counter, and completion pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            r_we        <= 1'b0;
            r_addr      <= 32'h0000_0000;
            r_be        <= 4'b0000;
            r_wdata     <= 32'h0000_0000;
            r_req       <= 1'b0;
            r_rdata     <= 32'h0000_0000;
            r_rdata_vld <= 1'b0;
            r_fault     <= 1'b0;
            r_cause     <= 2'b00;
        end else begin
            if (w_issue) begin
                r_cnt   <= '0;
                r_f3    <= i_funct3;
                r_off   <= i_addr[1:0];
                r_we    <= i_st;
                r_addr  <= {i_addr[31:2], 2'b00};
                r_be    <= calc_be(i_funct3, i_addr[1:0]);
                r_wdata <= calc_wdata(i_funct3, i_wdata);
            end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            r_req       <= (w_next == S_REQ);
            r_rdata_vld <= w_cap;
            r_fault     <= w_flt;
            r_cause     <= w_cause;
            if (w_cap) begin
                r_rdata <= fmt_load(r_f3, r_off, i_bus_rdata);
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

    assign o_rdata       = r_rdata;
    assign o_rdata_vld   = r_rdata_vld;
    assign o_fault       = r_fault;
    assign o_fault_cause = r_cause;
    assign o_bus_req     = r_req;
    assign o_bus_we      = r_we;
    assign o_bus_addr    = r_addr;
    assign o_bus_be      = r_be;
    assign o_bus_wdata   = r_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: the driver pushes expected bus beats and results,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_lsu_ctrl;

    localparam int TO = 8;

    logic        i_clk;
    logic        i_rst;
    logic        i_ld;
    logic        i_st;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic [31:0] o_rdata;
    logic        o_rdata_vld;
    logic        o_fault;
    logic [1:0]  o_fault_cause;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_gnt;
    logic        i_bus_rvld;
    logic [31:0] i_bus_rdata;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ld(i_ld), .i_st(i_st),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_stall(o_stall), .o_rdata(o_rdata), .o_rdata_vld(o_rdata_vld),
        .o_fault(o_fault), .o_fault_cause(o_fault_cause),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
        .i_bus_gnt(i_bus_gnt), .i_bus_rvld(i_bus_rvld), .i_bus_rdata(i_bus_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic        is_fault;
        logic [1:0]  cause;
        logic [31:0] data;
    } resp_t;

    bus_t        bus_q[$];
    resp_t       resp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_rdata = 32'h0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every accepted bus beat and every completion pulse.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_bus_req && i_bus_gnt) begin
                if (bus_q.size() == 0) begin
                    check("unexpected bus accept", 32'd1, 32'd0);
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    check("bus addr", o_bus_addr, b.addr);
                    check("bus we", {31'd0, o_bus_we}, {31'd0, b.we});
                    check("bus be", {28'd0, o_bus_be}, {28'd0, b.be});
                    if (b.we) check("bus wdata", o_bus_wdata, b.wdata);
                end
            end
            if (o_rdata_vld || o_fault) begin
                if (resp_q.size() == 0) begin
                    check("unexpected response", {30'd0, o_rdata_vld, o_fault}, 32'd0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check("fault flag", {31'd0, o_fault}, {31'd0, r.is_fault});
                    check("rdata_vld flag", {31'd0, o_rdata_vld}, {31'd0, !r.is_fault});
                    if (r.is_fault) check("fault cause", {30'd0, o_fault_cause}, {30'd0, r.cause});
                    else check("load data", o_rdata, r.data);
                end
            end
        end
    end

    // Issue one op in IDLE, play the bus side, and check stall/req cycle counts.
    task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rword, input int gnt_dly, input int rvld_dly);
        logic        illegal;
        logic        misal;
        int          size;
        int          lane;
        int          done_idx;
        int          exp_stall;
        int          exp_req;
        logic [31:0] bt;
        logic [31:0] hw;
        logic [31:0] res;
        bus_t        b;
        resp_t       r;
        int          stalls;
        int          reqs;
        int          since;
        bit          granted;
        bit          rv_given;
        bit          ok;

        size    = int'(f3) % 4;
        lane    = int'(addr % 4);
        illegal = (ld && st) || (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) || (st && f3 >= 3'd3);
        misal   = (size == 1 && lane % 2 != 0) || (size == 2 && lane != 0);
        exp_req = 0;
        if (illegal || misal) begin
            r.is_fault = 1'b1;
            r.cause    = illegal ? 2'b10 : 2'b01;
            r.data     = 32'h0;
            resp_q.push_back(r);
            exp_stall = 1;
        end else begin
            b.addr  = addr - (addr % 4);
            b.we    = st;
            b.be    = (size == 0) ? 4'(1 << lane) : (size == 1) ? ((lane >= 2) ? 4'b1100 : 4'b0011) : 4'b1111;
            b.wdata = (size == 0) ? (wdata & 32'hFF) * 32'h01010101 :
                      (size == 1) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
            if (gnt_dly < TO) bus_q.push_back(b);
            exp_req  = (gnt_dly < TO) ? gnt_dly + 1 : TO;
            done_idx = st ? gnt_dly : gnt_dly + rvld_dly;
            if (done_idx >= TO) begin
                r.is_fault = 1'b1;
                r.cause    = 2'b11;
                r.data     = 32'h0;
                resp_q.push_back(r);
                exp_stall = 1 + TO;
            end else begin
                exp_stall = 2 + done_idx;
                if (ld) begin
                    bt = (rword >> (8 * lane)) & 32'hFF;
                    hw = (rword >> (16 * (lane / 2))) & 32'hFFFF;
                    case (f3)
                        3'd0:    res = (bt >= 32'd128) ? (bt | 32'hFFFFFF00) : bt;
                        3'd1:    res = (hw >= 32'd32768) ? (hw | 32'hFFFF0000) : hw;
                        3'd4:    res = bt;
                        3'd5:    res = hw;
                        default: res = rword;
                    endcase
                    r.is_fault = 1'b0;
                    r.cause    = 2'b00;
                    r.data     = res;
                    resp_q.push_back(r);
                    last_rdata = res;
                end
            end
        end

        i_ld = ld; i_st = st; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
        i_bus_rdata = rword; i_bus_gnt = 1'b0; i_bus_rvld = 1'b0;
        #1;
        stalls = 0; reqs = 0; since = 0; granted = 0; rv_given = 0; ok = 0;
        for (int c = 0; c < 64; c++) begin
            if (!o_stall) begin
                ok = 1;
                break;
            end
            stalls++;
            if (o_bus_req) reqs++;
            i_bus_gnt = 1'b0; i_bus_rvld = 1'b0;
            if (granted) begin
                since++;
                if (ld && !rv_given && since == rvld_dly) begin
                    i_bus_rvld = 1'b1; rv_given = 1;
                end
            end else if (o_bus_req && (reqs - 1) == gnt_dly) begin
                i_bus_gnt = 1'b1; granted = 1; since = 0;
                if (ld && rvld_dly == 0) begin
                    i_bus_rvld = 1'b1; rv_given = 1;
                end
            end
            @(posedge i_clk); #1;
        end
        i_bus_gnt = 1'b0; i_bus_rvld = 1'b0;
        if (!ok) check("op completion within budget", 32'd0, 32'd1);
        check("stall cycles", stalls, exp_stall);
        check("req cycles", reqs, exp_req);
        check("rdata hold", o_rdata, last_rdata);
        @(posedge i_clk); #1;
        i_ld = 1'b0; i_st = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " ctrl outputs"},
              {23'd0, o_stall, o_rdata_vld, o_fault, o_fault_cause, o_bus_req, o_bus_we, o_bus_be[0]},
              32'd0);
        check({name, " rdata"}, o_rdata, 32'd0);
        check({name, " bus addr"}, o_bus_addr, 32'd0);
        check({name, " bus wdata"}, o_bus_wdata, 32'd0);
        check({name, " bus be"}, {28'd0, o_bus_be}, 32'd0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          sel;
        int          g;
        i_rst = 1'b1; i_ld = 1'b0; i_st = 1'b0; i_funct3 = 3'd0; i_addr = 32'h0;
        i_wdata = 32'h0; i_bus_gnt = 1'b0; i_bus_rvld = 1'b0; i_bus_rdata = 32'h0;
        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        do_op(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
        do_op(1'b1, 1'b0, 3'd0, 32'h203, 32'h0, 32'h80112233, 0, 2);
        do_op(1'b1, 1'b0, 3'd4, 32'h203, 32'h0, 32'h80112233, 0, 2);
        do_op(1'b0, 1'b1, 3'd1, 32'h102, 32'h0000ABCD, 32'h0, 0, 0);
        do_op(1'b1, 1'b0, 3'd1, 32'h101, 32'h0, 32'h0, 0, 0);
        do_op(1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0);
        do_op(1'b1, 1'b1, 3'd2, 32'h100, 32'h0, 32'h0, 0, 0);
        do_op(1'b0, 1'b1, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0);
        do_op(1'b1, 1'b0, 3'd1, 32'h202, 32'h0, 32'h80112233, 1, 1);
        do_op(1'b1, 1'b0, 3'd5, 32'h200, 32'h0, 32'h80112233, 0, 0);
        // Timeout with no grant, then a stray data beat in IDLE, then a normal lw.
        do_op(1'b0, 1'b1, 3'd2, 32'h180, 32'h11111111, 32'h0, 50, 0);
        i_bus_rvld = 1'b1;
        @(posedge i_clk); #1;
        i_bus_rvld = 1'b0;
        do_op(1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 32'h12345678, 1, 1);
        do_op(1'b0, 1'b1, 3'd0, 32'h301, 32'h000000A5, 32'h0, TO - 1, 0);
        do_op(1'b1, 1'b0, 3'd2, 32'h304, 32'h0, 32'hCAFEF00D, 3, TO - 4);
        do_op(1'b1, 1'b0, 3'd2, 32'h308, 32'h0, 32'hCAFEF00D, 3, TO - 3);

        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom % 16);
            f3  = 3'($urandom % 8);
            a   = $urandom;
            if ($urandom % 4 != 0) a = a & ~((f3[1:0] == 2'b10) ? 32'h3 : (f3[1:0] == 2'b01) ? 32'h1 : 32'h0);
            g   = ($urandom % 8 == 0) ? 12 : int'($urandom % 5);
            do_op(sel == 0 || sel < 8, sel == 0 || sel >= 8, f3, a, $urandom, $urandom, g, int'($urandom % 5));
        end

        // Reset while waiting for load data: everything clears and the late beat is dropped.
        bus_q.push_back('{addr: 32'h400, we: 1'b0, be: 4'b1111, wdata: 32'h0});
        i_ld = 1'b1; i_funct3 = 3'd2; i_addr = 32'h400; i_bus_rdata = 32'h55AA55AA;
        @(posedge i_clk); #1;
        check("req in REQ", {31'd0, o_bus_req}, 32'd1);
        i_bus_gnt = 1'b1;
        @(posedge i_clk); #1;
        i_bus_gnt = 1'b0;
        check("stall in WAIT", {31'd0, o_stall}, 32'd1);
        i_ld = 1'b0; i_rst = 1'b1; last_rdata = 32'h0;
        #1;
        check_all_zero("reset in WAIT");
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        i_bus_rvld = 1'b1;
        @(posedge i_clk); #1;
        i_bus_rvld = 1'b0;

        // Reset mid-cycle during REQ must drop the request without a clock edge.
        i_st = 1'b1; i_funct3 = 3'd2; i_addr = 32'h500;
        @(posedge i_clk); #1;
        i_st = 1'b0;
        check("req before reset", {31'd0, o_bus_req}, 32'd1);
        i_rst = 1'b1;
        #1;
        check("req dropped by async reset", {31'd0, o_bus_req}, 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        do_op(1'b1, 1'b0, 3'd4, 32'h602, 32'h0, 32'h00C30000, 0, 1);

        repeat (3) @(posedge i_clk);
        #1;
        check("bus queue drained", bus_q.size(), 32'd0);
        check("resp queue drained", resp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the RV32I execute stage and a single-outstanding data-memory bus. It accepts the decoded load/store request (ALU address, rs2 data, funct3), drives a req/gnt/rvld bus transaction, stalls the pipeline until completion, and returns sign- or zero-extended load data. It detects misaligned accesses, illegal funct3 values and bus timeouts, and reports them as faults without issuing a bus access.

## Interface
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before aborting with a timeout fault (≥2).

- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_ld  in  1  current instruction is a load (wb_sel = WB_MEM).
- i_st  in  1  current instruction is a store (st_mem).
- i_funct3  in  3  instruction bits [14:12].
- i_addr  in  32  effective address (ALU result).
- i_wdata  in  32  rs2 value.
- o_stall  out  1  hold the pipeline; the instruction and inputs remain stable while this is 1.
- o_rdata  out  32  formatted load result.
- o_rdata_vld  out  1  one-cycle pulse; o_rdata is valid for write-back.
- o_fault  out  1  one-cycle pulse; the access was aborted.
- o_fault_cause  out  2  01 misaligned, 10 illegal, 11 timeout, 00 none; valid while o_fault=1.
- o_bus_req  out  1  request; held until accepted.
- o_bus_we  out  1  1 = store.
- o_bus_addr  out  32  {i_addr[31:2],2'b00}.
- o_bus_be  out  4  byte enables.
- o_bus_wdata  out  32  lane-replicated store data.
- i_bus_gnt  in  1  request accepted when o_bus_req & i_bus_gnt.
- i_bus_rvld  in  1  load data valid.
- i_bus_rdata  in  32  load data word.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset: state IDLE, counter 0, every output 0, including o_rdata.
- IDLE: if i_ld|i_st, set o_stall=1 (combinationally) and check the request:
  - i_ld&i_st, load funct3 ∈ {011,110,111}, or store funct3 ≥ 011: go to DONE with cause 10.
  - Misaligned (halfword with addr[0]=1; word with addr[1:0]≠0): go to DONE with cause 01.
  - Otherwise: register the bus address, we, be and wdata, clear the counter, and go to REQ.
- Byte enables: byte = 0001<<addr[1:0]; half = 0011<<{addr[1],1'b0}; word = 1111. These apply to loads as well as stores.
- Store data: sb = {4{rs2[7:0]}}; sh = {2{rs2[15:0]}}; sw = rs2.
- REQ: o_bus_req=1.
  - On gnt, a store goes to DONE.
  - On gnt, a load goes to WAIT. If i_bus_rvld is also 1 in the same cycle, capture the data and go straight to DONE.
- WAIT: on i_bus_rvld, capture i_bus_rdata and go to DONE.
- Counter: increments every REQ/WAIT cycle. When it reaches TIMEOUT−1 without completion, drop req and go to DONE with cause 11. A gnt or rvld in that same cycle wins over the timeout.
- Load formatting: select the lane at addr[1:0] (halfword at addr[1]).
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - The result is registered on capture. o_rdata holds its value until the next capture.
- DONE: o_stall=0.
  - A successful load pulses o_rdata_vld.
  - A fault pulses o_fault with o_fault_cause.
  - A successful store pulses neither.
  - The next state is always IDLE; the pipeline advances at the end of DONE.
- i_bus_rvld or i_bus_gnt in IDLE or DONE is ignored; a late response after a timeout is discarded.
- Reset during REQ/WAIT drops o_bus_req immediately (asynchronously). Any pending response is ignored.

## Timing
- o_stall is combinational in IDLE; bus outputs and the o_rdata/o_fault pulses are registered.
- Store, gnt on first REQ cycle: cycle0 IDLE (stall), cycle1 REQ (req, gnt), cycle2 DONE (stall=0). Total 3 cycles, 2 stalled.
- Load, gnt then rvld one cycle later: IDLE, REQ, WAIT, DONE (rdata_vld) = 4 cycles. With gnt and rvld in the same cycle: 3 cycles.
- Fault (misaligned/illegal): IDLE, DONE = 2 cycles, no bus activity.
- Timeout: o_bus_req is high for at most TIMEOUT cycles.
- o_bus_* are stable from REQ entry until acceptance.
- Back-to-back memory ops: the second op is seen in the IDLE cycle after DONE. There are no idle bubbles beyond that.

## Test plan
- sw to addr 0x100, rs2=0xDEADBEEF, gnt on the first REQ cycle → be=1111, wdata=0xDEADBEEF, addr=0x100, we=1; stall high exactly 2 cycles; no rdata_vld or fault.
- lb at 0x203, rdata=0x80112233, rvld 2 cycles after gnt → be=1000, o_rdata=0xFFFFFF80 with rdata_vld in DONE. lbu at the same address → 0x00000080.
- sh at 0x102, rs2=0x0000ABCD → be=1100, wdata=0xABCDABCD. lh at 0x101 → no req, o_fault with cause 01 after 2 cycles.
- Load with funct3=011, and separately i_ld=i_st=1 → o_fault cause 10, o_bus_req never asserted.
- TIMEOUT=8, gnt held low → req high 8 cycles, then fault cause 11. A late rvld is ignored, and the next lw completes normally with correct data.
- Assert i_rst in WAIT → o_bus_req=0, all outputs 0, state IDLE. A subsequent rvld causes no rdata_vld.
